// File: rtl/brlite_local_ni_pkg.sv
// brlite_local_ni_pkg: BrLite flit/service types and the local NI FSM state types.
package brlite_local_ni_pkg;
  localparam int BR_ID_W = 8;
  localparam int BR_PAYLOAD_W = 16;
  typedef enum logic [1:0] {
    BR_SVC_TGT   = 2'd0,
    BR_SVC_MON   = 2'd1,
    BR_SVC_ALL   = 2'd2,
    BR_SVC_CLEAR = 2'd3
  } br_svc_t;
  typedef logic [BR_ID_W-1:0] br_id_t;
  typedef logic [BR_PAYLOAD_W-1:0] br_payload_t;
  typedef struct packed {
    logic [15:0] seq_source;
    logic [15:0] seq_target;
    br_svc_t     service;
    br_payload_t payload;
    br_id_t      id;
  } br_data_t;
  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_REQ = 2'd1, TX_RELEASE = 2'd2} br_ni_tx_state_t;
  typedef enum logic {RX_IDLE = 1'b0, RX_ACK = 1'b1} br_ni_rx_state_t;
endpackage

// File: rtl/brlite_local_ni_fifo.sv
// brlite_ni_fifo: synchronous FIFO for received flits.
//   i_push/i_data  write side (ignored when full, or when full and popping)
//   i_pop/o_data   read side (head, zero when empty)
//   o_full/o_empty/o_count  occupancy
module brlite_ni_fifo
  import brlite_local_ni_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = br_data_t,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        i_push,
  input  T            i_data,
  input  logic        i_pop,
  output T            o_data,
  output logic        o_full,
  output logic        o_empty,
  output logic [AW:0] o_count
);
  T r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_data  = o_empty ? T'('0) : r_mem[r_rd];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && !o_full;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= r_wr + AW'(w_push);
      r_rd    <= r_rd + AW'(w_pop);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk_i)
    if (w_push) r_mem[r_wr] <= i_data;
endmodule

// File: rtl/brlite_local_ni.sv
// brlite_local_ni: PE-side network interface on a BrLite router LOCAL port.
//   tx_*     PE message in (valid/ready), stamped with SEQ_ADDRESS and a wrapping id
//   br_*_o   req/ack injection into the router LOCAL input, gated by br_local_busy_i
//   br_*_i   req/ack delivery from the router LOCAL output
//   rx_*     buffered received flits to the PE (valid/ready, occupancy)
module brlite_local_ni
  import brlite_local_ni_pkg::*;
#(
  parameter logic [15:0] SEQ_ADDRESS = 16'h0,
  parameter int          RX_DEPTH    = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      tx_valid_i,
  output logic                      tx_ready_o,
  input  br_svc_t                   tx_service_i,
  input  logic [15:0]               tx_target_i,
  input  br_payload_t               tx_payload_i,
  output br_id_t                    tx_id_o,
  output logic                      rx_valid_o,
  input  logic                      rx_ready_i,
  output br_data_t                  rx_data_o,
  output logic [$clog2(RX_DEPTH):0] rx_count_o,
  output br_data_t                  br_flit_o,
  output logic                      br_req_o,
  input  logic                      br_ack_i,
  input  logic                      br_local_busy_i,
  input  br_data_t                  br_flit_i,
  input  logic                      br_req_i,
  output logic                      br_ack_o
);
  br_ni_tx_state_t r_tx_state;
  br_ni_rx_state_t r_rx_state;
  br_data_t r_flit;
  br_id_t r_id_cnt, r_tx_id;
  logic w_accept, w_capture, w_push, w_full, w_empty;
  assign tx_ready_o = r_tx_state == TX_IDLE && !br_local_busy_i;
  assign w_accept   = tx_valid_i && tx_ready_o;
  assign br_req_o   = r_tx_state == TX_REQ;
  assign br_flit_o  = r_flit;
  assign tx_id_o    = r_tx_id;
  // CLEAR messages complete the valid/ready handshake but are never injected.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_tx_state <= TX_IDLE;
      r_flit     <= '0;
      r_id_cnt   <= '0;
      r_tx_id    <= '0;
    end else begin
      case (r_tx_state)
        TX_IDLE:
          if (w_accept && tx_service_i != BR_SVC_CLEAR) begin
            r_flit     <= '{seq_source: SEQ_ADDRESS, seq_target: tx_target_i,
                            service: tx_service_i, payload: tx_payload_i, id: r_id_cnt};
            r_tx_id    <= r_id_cnt;
            r_id_cnt   <= r_id_cnt + 1'b1;
            r_tx_state <= TX_REQ;
          end
        TX_REQ:     if (br_ack_i) r_tx_state <= TX_RELEASE;
        TX_RELEASE: if (!br_ack_i) r_tx_state <= TX_IDLE;
        default:    r_tx_state <= TX_IDLE;
      endcase
    end
  // Capture only from RX_IDLE: the router still holds req during our ack cycle.
  assign w_capture = r_rx_state == RX_IDLE && br_req_i && !w_full;
  assign w_push    = w_capture && br_flit_i.service != BR_SVC_CLEAR;
  assign br_ack_o  = r_rx_state == RX_ACK;
  assign rx_valid_o = !w_empty;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_rx_state <= RX_IDLE;
    else r_rx_state <= w_capture ? RX_ACK : RX_IDLE;
  brlite_ni_fifo #(.DEPTH(RX_DEPTH), .T(br_data_t)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_push),
    .i_data  (br_flit_i),
    .i_pop   (rx_ready_i),
    .o_data  (rx_data_o),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (rx_count_o)
  );
endmodule

// File: tb/tb_brlite_local_ni.sv
// tb_brlite_local_ni: directed scoreboard bench for the BrLite local NI.
module tb_brlite_local_ni;
  import brlite_local_ni_pkg::*;
  localparam logic [15:0] SEQ = 16'h0A5C;
  localparam int DEPTH = 4;
  logic clk_i = 0, rst_ni = 0;
  logic tx_valid_i = 0, tx_ready_o;
  br_svc_t tx_service_i = BR_SVC_TGT;
  logic [15:0] tx_target_i = '0;
  br_payload_t tx_payload_i = '0;
  br_id_t tx_id_o;
  logic rx_valid_o, rx_ready_i = 0;
  br_data_t rx_data_o, br_flit_o, br_flit_i = '0;
  logic [$clog2(DEPTH):0] rx_count_o;
  logic br_req_o, br_ack_i = 0, br_local_busy_i = 0, br_req_i = 0, br_ack_o;
  int n_test = 0, n_fail = 0;
  br_data_t tx_q[$], rx_q[$];
  br_id_t exp_id = '0;
  brlite_local_ni #(.SEQ_ADDRESS(SEQ), .RX_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_service_i(tx_service_i),
    .tx_target_i(tx_target_i), .tx_payload_i(tx_payload_i), .tx_id_o(tx_id_o),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_data_o(rx_data_o), .rx_count_o(rx_count_o),
    .br_flit_o(br_flit_o), .br_req_o(br_req_o), .br_ack_i(br_ack_i), .br_local_busy_i(br_local_busy_i),
    .br_flit_i(br_flit_i), .br_req_i(br_req_i), .br_ack_o(br_ack_o)
  );
  always #5 clk_i = ~clk_i;
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_test++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask
  function automatic br_data_t mk(input logic [15:0] src, input logic [15:0] tgt, input br_svc_t s,
                                  input br_payload_t p, input br_id_t id);
    br_data_t f;
    f.seq_source = src;
    f.seq_target = tgt;
    f.service = s;
    f.payload = p;
    f.id = id;
    return f;
  endfunction
  task automatic do_reset();
    rst_ni = 0;
    tx_valid_i = 0; rx_ready_i = 0; br_ack_i = 0; br_req_i = 0; br_local_busy_i = 0; br_flit_i = '0;
    tick(2);
    rst_ni = 1;
    tick();
    exp_id = '0;
    tx_q.delete();
    rx_q.delete();
  endtask
  task automatic tx_router(input int dly);
    br_data_t e;
    e = tx_q.pop_front();
    chk("tx_flit", br_flit_o, e);
    chk("tx_id", tx_id_o, e.id);
    tick(dly);
    chk("tx_req_hold", br_req_o, 1);
    br_ack_i = 1;
    tick();
    chk("tx_req_drop", br_req_o, 0);
    chk("tx_ready_rel", tx_ready_o, 0);
    br_ack_i = 0;
    tick();
    chk("tx_ready_back", tx_ready_o, !br_local_busy_i);
  endtask
  task automatic tx_send(input br_svc_t s, input logic [15:0] t, input br_payload_t p, input int dly);
    int k = 0;
    tx_valid_i = 1; tx_service_i = s; tx_target_i = t; tx_payload_i = p;
    #1;
    while (!tx_ready_o && k < 50) begin tick(); k++; end
    chk("tx_ready", tx_ready_o, 1);
    tx_q.push_back(mk(SEQ, t, s, p, exp_id));
    exp_id++;
    tick();
    tx_valid_i = 0;
    chk("tx_req_rise", br_req_o, 1);
    tx_router(dly);
  endtask
  task automatic rx_send(input br_data_t f);
    br_req_i = 1; br_flit_i = f;
    tick();
    chk("rx_ack_lat", br_ack_o, 1);
    if (f.service != BR_SVC_CLEAR) rx_q.push_back(f);
    tick();
    br_req_i = 0; br_flit_i = '0;
    chk("rx_ack_1cyc", br_ack_o, 0);
  endtask
  task automatic rx_pop();
    br_data_t e;
    chk("rx_sb_nonempty", rx_q.size() != 0, 1);
    e = rx_q.size() != 0 ? rx_q.pop_front() : '0;
    chk("rx_valid", rx_valid_o, 1);
    chk("rx_data", rx_data_o, e);
    rx_ready_i = 1;
    tick();
    rx_ready_i = 0;
  endtask
  initial begin
    logic viol;
    br_data_t f5;
    do_reset();
    chk("rst_req", br_req_o, 0);
    chk("rst_ack", br_ack_o, 0);
    chk("rst_rx_valid", rx_valid_o, 0);
    chk("rst_count", rx_count_o, 0);
    chk("rst_tx_id", tx_id_o, 0);
    chk("rst_flit", br_flit_o, 0);
    chk("rst_rx_data", rx_data_o, 0);
    chk("rst_ready", tx_ready_o, 1);
    // 1: single TGT message, router acks after 3 cycles
    tx_send(BR_SVC_TGT, 16'd5, 16'h00AB, 3);
    // 2: local_busy gates accepts; busy rising mid-handshake is ignored
    br_local_busy_i = 1;
    tx_valid_i = 1; tx_service_i = BR_SVC_MON; tx_target_i = 16'd3; tx_payload_i = 16'h0055;
    viol = 0;
    repeat (20) begin tick(); viol |= tx_ready_o | br_req_o; end
    chk("busy_blocks", viol, 0);
    br_local_busy_i = 0;
    #1;
    chk("busy_drop_ready", tx_ready_o, 1);
    tx_q.push_back(mk(SEQ, 16'd3, BR_SVC_MON, 16'h0055, exp_id));
    exp_id++;
    tick();
    tx_valid_i = 0;
    chk("busy_accept_req", br_req_o, 1);
    br_local_busy_i = 1;
    tx_router(1);
    br_local_busy_i = 0;
    #1;
    // 3: one-shot router delivery -> exactly one entry
    rx_send(mk(16'h0007, SEQ, BR_SVC_ALL, 16'h1234, 8'h09));
    tick();
    chk("rx_one_entry", rx_count_o, 1);
    rx_pop();
    chk("rx_empty_after", rx_valid_o, 0);
    rx_send(mk(16'h0008, SEQ, BR_SVC_CLEAR, 16'h0001, 8'h01));
    chk("rx_clear_dropped", rx_count_o, 0);
    // 4: fill FIFO, 5th held unacked until a pop
    for (int i = 0; i < 4; i++) rx_send(mk(16'h0100 + 16'(i), SEQ, BR_SVC_TGT, 16'hC000 + 16'(i), 8'(i)));
    chk("rx_full_count", rx_count_o, 4);
    f5 = mk(16'h0104, SEQ, BR_SVC_MON, 16'hC004, 8'h04);
    br_req_i = 1; br_flit_i = f5;
    viol = 0;
    repeat (6) begin tick(); viol |= br_ack_o; end
    chk("rx_full_noack", viol, 0);
    chk("rx_full_hold", rx_count_o, 4);
    rx_pop();
    chk("rx_push_waits", br_ack_o, 0);
    chk("rx_pop_count", rx_count_o, 3);
    tick();
    chk("rx_5th_ack", br_ack_o, 1);
    rx_q.push_back(f5);
    tick();
    br_req_i = 0; br_flit_i = '0;
    chk("rx_5th_count", rx_count_o, 4);
    repeat (4) rx_pop();
    chk("rx_drain_count", rx_count_o, 0);
    chk("rx_drain_valid", rx_valid_o, 0);
    // 5: 257 messages -> ids 0..255 then 0; CLEAR dropped, id unchanged
    do_reset();
    for (int i = 0; i < 257; i++)
      tx_send(i % 3 == 0 ? BR_SVC_TGT : (i % 3 == 1 ? BR_SVC_MON : BR_SVC_ALL), 16'(i), 16'(i * 3), 0);
    chk("wrap_id", tx_id_o, 0);
    tx_valid_i = 1; tx_service_i = BR_SVC_CLEAR; tx_target_i = 16'd9; tx_payload_i = 16'hDEAD;
    #1;
    chk("clear_ready", tx_ready_o, 1);
    tick();
    tx_valid_i = 0;
    chk("clear_no_req", br_req_o, 0);
    chk("clear_id", tx_id_o, 0);
    tick();
    chk("clear_no_req2", br_req_o, 0);
    tx_send(BR_SVC_TGT, 16'd11, 16'h0101, 1);
    // 6: reset in TX_REQ with FIFO holding 2
    tx_valid_i = 1; tx_service_i = BR_SVC_TGT; tx_target_i = 16'd2; tx_payload_i = 16'h0F0F;
    tick();
    tx_valid_i = 0;
    chk("mid_req", br_req_o, 1);
    rx_send(mk(16'h0201, SEQ, BR_SVC_TGT, 16'h0A0A, 8'h11));
    rx_send(mk(16'h0202, SEQ, BR_SVC_ALL, 16'h0B0B, 8'h12));
    chk("mid_count", rx_count_o, 2);
    #2;
    rst_ni = 0; br_req_i = 0; br_ack_i = 0;
    #1;
    chk("arst_req", br_req_o, 0);
    chk("arst_rx_valid", rx_valid_o, 0);
    chk("arst_count", rx_count_o, 0);
    chk("arst_id", tx_id_o, 0);
    chk("arst_flit", br_flit_o, 0);
    tick();
    rst_ni = 1;
    tick();
    exp_id = '0;
    tx_q.delete();
    rx_q.delete();
    tx_send(BR_SVC_ALL, 16'd4, 16'h7777, 2);
    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end
endmodule
